// File: rtl/store_merge.sv
// -----------------------------------------------------------------------------
// store_merge
//
// Write-side byte-lane unit between the execute/memory stage and a
// word-addressed data memory. A word store (sw) goes straight to a single
// write. A halfword store (sh) or byte store (sb) is a read-modify-write:
// read the word, merge the new lane(s), then write the word back.
// Misaligned or reserved requests end in a one-cycle done+err pulse and
// never touch memory.
//
// Parameters:
//   RD_LAT     memory read latency (1..3) from mem_rd_en to valid mem_rdata
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   req_valid  request present
//   req_ready  unit can accept a request (high only in IDLE)
//   req_op     0=sw, 1=sh, 2=sb, 3=reserved
//   req_addr   byte address
//   req_wdata  store data (sb uses [7:0], sh uses [15:0])
//   mem_addr   word address to memory, bits [1:0] always 0
//   mem_rd_en  one-cycle read strobe
//   mem_rdata  read data, valid RD_LAT cycles after mem_rd_en
//   mem_wr_en  one-cycle write strobe
//   mem_wdata  full word to write
//   done       one-cycle pulse, request finished
//   err        one-cycle pulse together with done, request rejected
// -----------------------------------------------------------------------------
module store_merge #(
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] mem_addr,
   output logic        mem_rd_en,
   input  logic [31:0] mem_rdata,
   output logic        mem_wr_en,
   output logic [31:0] mem_wdata,
   output logic        done,
   output logic        err
);

   localparam logic [1:0] OP_SW = 2'd0;
   localparam logic [1:0] OP_SH = 2'd1;
   localparam logic [1:0] OP_SB = 2'd2;

   // WAIT lasts RD_LAT cycles; the counter runs 0..RD_LAT-1.
   localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WAIT,
      S_WR,
      S_ERR
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic        w_accept;
   logic        w_bad;

   // Captured request: only the fields the merge needs are kept.
   logic        r_is_sb;
   logic [1:0]  r_lane;
   logic [15:0] r_wdata_lo;
   logic [1:0]  r_cnt;

   logic        r_rd_en;
   logic        r_wr_en;
   logic        r_done;
   logic        r_err;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;

   logic [3:0]  w_lane_sel;
   logic [31:0] w_merged;

   assign w_accept = req_valid && (r_state == S_IDLE);

   // Alignment / legality check on the live request inputs.
   always_comb begin
      w_bad = 1'b0;
      case (req_op)
         OP_SW:   w_bad = (req_addr[1:0] != 2'b00);
         OP_SH:   w_bad = req_addr[0];
         OP_SB:   w_bad = 1'b0;
         default: w_bad = 1'b1;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_bad)                 w_state_next = S_ERR;
               else if (req_op == OP_SW)  w_state_next = S_WR;
               else                       w_state_next = S_RD;
            end
         end
         S_RD:   w_state_next = S_WAIT;
         S_WAIT: begin
            if (r_cnt == CNT_LAST) w_state_next = S_WR;
         end
         S_WR:   w_state_next = S_IDLE;
         S_ERR:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Lane merge: each byte lane takes either the new store data or the word
   // just read back. sh only ever selects an aligned pair, so lane gi of a
   // halfword takes byte (gi % 2) of the store data.
   // -------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE    = 2'(gi);
         localparam int         HALF_LO = (gi % 2) * 8;

         assign w_lane_sel[gi] = r_is_sb ? (r_lane == LANE) : (r_lane[1] == LANE[1]);

         assign w_merged[8*gi +: 8] = !w_lane_sel[gi] ? mem_rdata[8*gi +: 8] :
                                      r_is_sb         ? r_wdata_lo[7:0]      :
                                                        r_wdata_lo[HALF_LO +: 8];
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Datapath and registered outputs. Strobes are registered from the next
   // state so they line up exactly with the state they belong to.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_is_sb     <= 1'b0;
         r_lane      <= 2'b00;
         r_wdata_lo  <= 16'h0000;
         r_cnt       <= 2'd0;
         r_rd_en     <= 1'b0;
         r_wr_en     <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_mem_addr  <= 32'h0000_0000;
         r_mem_wdata <= 32'h0000_0000;
      end else begin
         if (w_accept) begin
            r_is_sb    <= (req_op == OP_SB);
            r_lane     <= req_addr[1:0];
            r_wdata_lo <= req_wdata[15:0];
         end

         r_cnt   <= (r_state == S_WAIT) ? r_cnt + 2'd1 : 2'd0;

         r_rd_en <= (w_state_next == S_RD);
         r_wr_en <= (w_state_next == S_WR);
         r_done  <= (w_state_next == S_WR) || (w_state_next == S_ERR);
         r_err   <= (w_state_next == S_ERR);

         // Address is loaded only when a memory access starts; it holds
         // through WAIT and after the strobes drop.
         if ((r_state == S_IDLE) &&
             ((w_state_next == S_RD) || (w_state_next == S_WR))) begin
            r_mem_addr <= {req_addr[31:2], 2'b00};
         end

         // sw writes the request data verbatim; sh/sb write the merged word,
         // sampled on the edge that ends the last WAIT cycle.
         if ((r_state == S_IDLE) && (w_state_next == S_WR)) begin
            r_mem_wdata <= req_wdata;
         end else if ((r_state == S_WAIT) && (w_state_next == S_WR)) begin
            r_mem_wdata <= w_merged;
         end
      end
   end

   assign req_ready = (r_state == S_IDLE);
   assign mem_rd_en = r_rd_en;
   assign mem_wr_en = r_wr_en;
   assign done      = r_done;
   assign err       = r_err;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule
